// File: rtl/sw_debounce.sv
// sw_debounce: per-channel switch conditioner.
// Each channel is synchronised with two flops, filtered by a stability
// counter, and presented as a clean level plus one-cycle rise/fall pulses.
// All outputs are registered, so nothing combinational runs from SW_IN to them.
module sw_debounce #(
   parameter int N_SW            = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [N_SW-1:0] SW_IN,
   output logic [N_SW-1:0] SW_LEVEL,
   output logic [N_SW-1:0] SW_RISE,
   output logic [N_SW-1:0] SW_FALL
);

   // Counter width is derived from the threshold and is not meant to be overridden.
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // Terminal count: the sample that reaches this value commits the new level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_SW-1:0]  sync1;
   logic [N_SW-1:0]  sync2;
   logic [CNT_W-1:0] cnt [N_SW];

   // Two-flop synchroniser bringing the asynchronous switch pins into the CLK domain.
   // NOTE: sequential state is always written with <=, so sync2 takes the old sync1 value.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= SW_IN;
         sync2 <= sync1;
      end
   end

   // Stability filter with registered edge pulses. Channels are evaluated independently.
   // NOTE: the pulses default to 0 at every edge, so each one lasts only one cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         SW_LEVEL <= '0;
         SW_RISE  <= '0;
         SW_FALL  <= '0;
         for (int i = 0; i < N_SW; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_SW; i++) begin
            SW_RISE[i] <= 1'b0;
            SW_FALL[i] <= 1'b0;
            if (sync2[i] == SW_LEVEL[i]) begin
               // The input agrees with the accepted level, so any pending change is abandoned.
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               // The input has been stable for long enough, so the new level is accepted.
               SW_LEVEL[i] <= sync2[i];
               SW_RISE[i]  <= sync2[i];
               SW_FALL[i]  <= ~sync2[i];
               cnt[i]      <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: scoreboard bench for sw_debounce.
// Two instances share the same stimulus: one with DEBOUNCE_CYCLES=4 and one with
// DEBOUNCE_CYCLES=1. The expected outputs for every edge are pushed when the
// stimulus is driven and are popped one cycle later, #1 after the clock edge.
module tb_sw_debounce;

   localparam int MAXC = 1024;

   typedef struct packed {
      logic [1:0] level;
      logic [1:0] rise;
      logic [1:0] fall;
   } outs_t;

   typedef struct packed {
      int    k;
      outs_t o4;
      outs_t o1;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] sw_in = 2'b00;
   logic [1:0] lvl4, rise4, fall4;
   logic [1:0] lvl1, rise1, fall1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   sb_t sb[$];

   // Reference state: a window-based view of the filter. A level changes at edge k
   // when every sample the filter saw in the last D edges disagrees with the level,
   // and none of those edges had a change or a reset.
   logic       rst_hist [MAXC];
   logic [1:0] sw_hist  [MAXC];
   logic [1:0] f_hist   [2][MAXC];
   logic [1:0] m_level  [2];
   int         m_last   [2][2];

   // Per-phase statistics gathered from the DUT outputs
   int rise_cnt   [2][2];
   int fall_cnt   [2][2];
   int first_rise [2][2];
   int first_fall [2][2];

   always #10 clk = ~clk;

   sw_debounce #(.N_SW(2), .DEBOUNCE_CYCLES(4)) dut4 (
      .CLK(clk), .RST(rst), .SW_IN(sw_in),
      .SW_LEVEL(lvl4), .SW_RISE(rise4), .SW_FALL(fall4)
   );

   sw_debounce #(.N_SW(2), .DEBOUNCE_CYCLES(1)) dut1 (
      .CLK(clk), .RST(rst), .SW_IN(sw_in),
      .SW_LEVEL(lvl1), .SW_RISE(rise1), .SW_FALL(fall1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s (edge %0d): got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Reference model for one instance at edge k. It uses the input that was applied two
   // edges earlier because of the synchroniser.
   task automatic model_step(input int d, input int dc, input int k, output outs_t o);
      logic [1:0] f;
      bit         all_diff;
      o = '0;
      if (rst_hist[k]) begin
         m_level[d]   = 2'b00;
         m_last[d][0] = k;
         m_last[d][1] = k;
         f_hist[d][k] = 2'b00;
      end else begin
         f = (k < 2 || rst_hist[k-1] || rst_hist[k-2]) ? 2'b00 : sw_hist[k-2];
         f_hist[d][k] = f;
         for (int i = 0; i < 2; i++) begin
            if (k - dc >= m_last[d][i]) begin
               all_diff = 1'b1;
               for (int j = k - dc + 1; j <= k; j++) begin
                  if (f_hist[d][j][i] == m_level[d][i]) all_diff = 1'b0;
               end
               if (all_diff) begin
                  m_level[d][i] = ~m_level[d][i];
                  m_last[d][i]  = k;
                  if (m_level[d][i]) o.rise[i] = 1'b1;
                  else               o.fall[i] = 1'b1;
               end
            end
         end
      end
      o.level = m_level[d];
   endtask

   // Apply inputs for n edges, pushing the expected outcome of each edge, then let the last edge occur.
   task automatic drive(input logic [1:0] v, input logic r, input int n);
      outs_t o4, o1;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         sw_in = v;
         rst   = r;
         sw_hist[cyc]  = v;
         rst_hist[cyc] = r;
         model_step(0, 4, cyc, o4);
         model_step(1, 1, cyc, o1);
         sb.push_back('{k: cyc, o4: o4, o1: o1});
         cyc++;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic clear_stats();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 2; i++) begin
            rise_cnt[d][i]   = 0;
            fall_cnt[d][i]   = 0;
            first_rise[d][i] = -1;
            first_fall[d][i] = -1;
         end
      end
   endtask

   // Monitor: pop the expectation for the edge just taken and compare it with both instances.
   always begin
      sb_t   e;
      outs_t obs [2];
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         obs[0] = '{level: lvl4, rise: rise4, fall: fall4};
         obs[1] = '{level: lvl1, rise: rise1, fall: fall1};
         check("level_d4", 32'(obs[0].level), 32'(e.o4.level));
         check("rise_d4",  32'(obs[0].rise),  32'(e.o4.rise));
         check("fall_d4",  32'(obs[0].fall),  32'(e.o4.fall));
         check("level_d1", 32'(obs[1].level), 32'(e.o1.level));
         check("rise_d1",  32'(obs[1].rise),  32'(e.o1.rise));
         check("fall_d1",  32'(obs[1].fall),  32'(e.o1.fall));
         check("rise_and_fall_d4", 32'(rise4 & fall4), 32'd0);
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
               if (obs[d].rise[i]) begin
                  rise_cnt[d][i]++;
                  if (first_rise[d][i] < 0) first_rise[d][i] = e.k;
               end
               if (obs[d].fall[i]) begin
                  fall_cnt[d][i]++;
                  if (first_fall[d][i] < 0) first_fall[d][i] = e.k;
               end
            end
         end
      end
   end

   // Watchdog so that the run always ends, even if the main sequence stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      for (int d = 0; d < 2; d++) begin
         m_level[d]   = 2'b00;
         m_last[d][0] = 0;
         m_last[d][1] = 0;
      end
      clear_stats();

      // Reset state
      drive(2'b00, 1'b1, 3);
      check("reset_level_d4", 32'(lvl4), 32'd0);
      check("reset_pulses_d4", 32'({rise4, fall4}), 32'd0);
      check("reset_level_d1", 32'(lvl1), 32'd0);

      // 1. Clean rise on channel 0
      clear_stats();
      e0 = cyc;
      drive(2'b01, 1'b0, 8);
      check("t1_latency_d4", 32'(first_rise[0][0] - e0), 32'd5);
      check("t1_latency_d1", 32'(first_rise[1][0] - e0), 32'd2);
      check("t1_rise_cnt_d4", 32'(rise_cnt[0][0]), 32'd1);
      check("t1_ch1_quiet_d4", 32'(rise_cnt[0][1]), 32'd0);
      check("t1_no_fall_d4", 32'(fall_cnt[0][0] + fall_cnt[0][1]), 32'd0);

      // 2. Bounce rejection on channel 0
      drive(2'b00, 1'b0, 8);
      clear_stats();
      e0 = cyc;
      drive(2'b01, 1'b0, 1);
      drive(2'b00, 1'b0, 1);
      drive(2'b01, 1'b0, 3);
      drive(2'b00, 1'b0, 1);
      drive(2'b01, 1'b0, 8);
      check("t2_rise_cnt_d4", 32'(rise_cnt[0][0]), 32'd1);
      check("t2_rise_edge_d4", 32'(first_rise[0][0] - e0), 32'd11);
      check("t2_fall_cnt_d4", 32'(fall_cnt[0][0]), 32'd0);
      check("t2_rise_cnt_d1", 32'(rise_cnt[1][0]), 32'd3);
      check("t2_fall_cnt_d1", 32'(fall_cnt[1][0]), 32'd2);

      // 3. Exact threshold on channel 1: three samples are rejected, four are accepted
      drive(2'b00, 1'b0, 8);
      clear_stats();
      drive(2'b10, 1'b0, 3);
      drive(2'b00, 1'b0, 8);
      check("t3_short_rise_d4", 32'(rise_cnt[0][1]), 32'd0);
      check("t3_short_level_d4", 32'(lvl4), 32'd0);
      clear_stats();
      e0 = cyc;
      drive(2'b10, 1'b0, 4);
      drive(2'b00, 1'b0, 10);
      check("t3_rise_cnt_d4", 32'(rise_cnt[0][1]), 32'd1);
      check("t3_rise_edge_d4", 32'(first_rise[0][1] - e0), 32'd5);
      check("t3_fall_cnt_d4", 32'(fall_cnt[0][1]), 32'd1);
      check("t3_fall_edge_d4", 32'(first_fall[0][1] - e0), 32'd9);

      // 4. Simultaneous channels
      clear_stats();
      e0 = cyc;
      drive(2'b11, 1'b0, 8);
      check("t4_rise0_edge_d4", 32'(first_rise[0][0] - e0), 32'd5);
      check("t4_rise1_edge_d4", 32'(first_rise[0][1] - e0), 32'd5);
      clear_stats();
      drive(2'b10, 1'b0, 8);
      check("t4_fall0_cnt_d4", 32'(fall_cnt[0][0]), 32'd1);
      check("t4_fall1_cnt_d4", 32'(fall_cnt[0][1]), 32'd0);
      check("t4_level_d4", 32'(lvl4), 32'd2);

      // 5. Reset while a fall is being counted
      drive(2'b11, 1'b0, 8);
      check("t5_pre_level_d4", 32'(lvl4), 32'd3);
      clear_stats();
      drive(2'b00, 1'b0, 4);
      drive(2'b00, 1'b1, 1);
      check("t5_reset_level_d4", 32'(lvl4), 32'd0);
      drive(2'b00, 1'b0, 20);
      check("t5_fall_cnt_d4", 32'(fall_cnt[0][0] + fall_cnt[0][1]), 32'd0);
      check("t5_rise_cnt_d4", 32'(rise_cnt[0][0] + rise_cnt[0][1]), 32'd0);
      check("t5_final_level_d4", 32'(lvl4), 32'd0);

      // 6. Switches already high at reset release
      drive(2'b11, 1'b1, 3);
      clear_stats();
      e0 = cyc;
      drive(2'b11, 1'b0, 8);
      check("t6_rise0_edge_d4", 32'(first_rise[0][0] - e0), 32'd5);
      check("t6_rise1_edge_d4", 32'(first_rise[0][1] - e0), 32'd5);
      check("t6_rise0_edge_d1", 32'(first_rise[1][0] - e0), 32'd2);
      check("t6_rise1_edge_d1", 32'(first_rise[1][1] - e0), 32'd2);
      check("t6_rise_cnt_d4", 32'(rise_cnt[0][0] + rise_cnt[0][1]), 32'd2);
      check("t6_level_d4", 32'(lvl4), 32'd3);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
